// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester and shared memory bus signals of mem_bus_arbiter
interface mem_bus_arbiter_if #(
    parameter int LINE_W = 512
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_ack;
    logic              i_err;
    logic [LINE_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [LINE_W-1:0] d_rdata;
    logic              mem_addr_valid;
    logic [31:0]       mem_addr;
    logic              mem_write_data_valid;
    logic [LINE_W-1:0] mem_write_data;
    logic              mem_read_data_ready;
    logic [LINE_W-1:0] mem_read_data;
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_read_data_ready, mem_read_data,
        output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               mem_addr_valid, mem_addr, mem_write_data_valid, mem_write_data
    );
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_read_data_ready, mem_read_data,
        input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               mem_addr_valid, mem_addr, mem_write_data_valid, mem_write_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: instruction/data requester arbiter onto one memory bus; MEM_ARB_TIMEOUT_EN adds a BUSY timeout
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int LINE_W = 512
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state;
    logic              ptr;
    logic              gnt_d;
    logic              we;
    logic              sel_d;
    logic              sel_we;
    logic              dec_err;
    logic              tmo;
    logic [31:0]       sel_addr;
    logic [LINE_W-1:0] rd_line;
    // grant choice, address decode and completion line for the current cycle
    always_comb begin
        sel_d = bus.d_req && (!bus.i_req || ptr);
        sel_addr = sel_d ? bus.d_addr : bus.i_addr;
        sel_we = sel_d && bus.d_we;
        dec_err = (sel_addr[31:15] != 17'd0 && sel_addr[31:14] != 18'd2) || (sel_we && sel_addr[31:15] == 17'd0);
        rd_line = (bus.mem_read_data_ready && !we) ? bus.mem_read_data : '0;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // counts BUSY cycles; expires on the TIMEOUT_CYCLES-th one
    always_ff @(posedge clk) begin
        cnt <= (rst || state != BUSY) ? '0 : cnt + 1'b1;
    end
    // timeout strobe; ready in the same cycle still completes normally
    always_comb begin
        tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
    end
`else
    // no timeout: BUSY waits for ready indefinitely
    always_comb begin
        tmo = TIMEOUT_CYCLES < 0;
    end
`endif
    // arbitration FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= 1'b0;
            gnt_d <= 1'b0;
            we <= 1'b0;
            bus.i_ack <= 1'b0;
            bus.i_err <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_ack <= 1'b0;
            bus.d_err <= 1'b0;
            bus.d_rdata <= '0;
            bus.mem_addr_valid <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_write_data_valid <= 1'b0;
            bus.mem_write_data <= '0;
        end else begin
            bus.i_ack <= 1'b0;
            bus.i_err <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.d_err <= 1'b0;
            case (state)
                IDLE: if (bus.i_req || bus.d_req) begin
                    gnt_d <= sel_d;
                    we <= sel_we;
                    if (dec_err) begin
                        state <= RESP;
                        bus.i_ack <= !sel_d;
                        bus.i_err <= !sel_d;
                        bus.d_ack <= sel_d;
                        bus.d_err <= sel_d;
                        bus.i_rdata <= sel_d ? bus.i_rdata : '0;
                        bus.d_rdata <= sel_d ? '0 : bus.d_rdata;
                    end else begin
                        state <= BUSY;
                        bus.mem_addr_valid <= 1'b1;
                        bus.mem_addr <= sel_addr;
                        bus.mem_write_data_valid <= sel_we;
                        bus.mem_write_data <= sel_we ? bus.d_wdata : '0;
                    end
                end
                BUSY: if (bus.mem_read_data_ready || tmo) begin
                    state <= RESP;
                    bus.mem_addr_valid <= 1'b0;
                    bus.mem_addr <= '0;
                    bus.mem_write_data_valid <= 1'b0;
                    bus.mem_write_data <= '0;
                    bus.i_ack <= !gnt_d;
                    bus.i_err <= !gnt_d && !bus.mem_read_data_ready;
                    bus.d_ack <= gnt_d;
                    bus.d_err <= gnt_d && !bus.mem_read_data_ready;
                    bus.i_rdata <= gnt_d ? bus.i_rdata : rd_line;
                    bus.d_rdata <= gnt_d ? rd_line : bus.d_rdata;
                end
                RESP: begin
                    state <= IDLE;
                    ptr <= !gnt_d;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized self-checking bench for mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
    localparam int LW = 512;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
    localparam int TMO = 8;
`else
    localparam int TO = 64;
    localparam int TMO = 1 << 30;
`endif
    typedef logic [LW-1:0] line_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_bus_arbiter_if #(.LINE_W(LW)) bus ();
    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;
    logic mptr = 1'b0;
    logic [31:0] gl[$];
    logic e_valid = 0, e_wv = 0, e_iack = 0, e_ierr = 0, e_dack = 0, e_derr = 0;
    logic [31:0] e_addr = 0;
    line_t e_wd = '0, e_irdata = '0, e_drdata = '0;
    task automatic chk(input string n, input line_t a, input line_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h want %h", n, $time, a, e);
        end
    endtask
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_addr_valid", line_t'(bus.mem_addr_valid), line_t'(e_valid));
            chk("mem_write_data_valid", line_t'(bus.mem_write_data_valid), line_t'(e_wv));
            chk("i_ack", line_t'(bus.i_ack), line_t'(e_iack));
            chk("i_err", line_t'(bus.i_err), line_t'(e_ierr));
            chk("d_ack", line_t'(bus.d_ack), line_t'(e_dack));
            chk("d_err", line_t'(bus.d_err), line_t'(e_derr));
            chk("i_rdata", bus.i_rdata, e_irdata);
            chk("d_rdata", bus.d_rdata, e_drdata);
            if (e_valid) begin
                chk("mem_addr", line_t'(bus.mem_addr), line_t'(e_addr));
                chk("mem_write_data", bus.mem_write_data, e_wd);
            end
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic line_t rline();
        line_t l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction
    function automatic logic [31:0] raddr();
        int c;
        c = $urandom_range(4);
        if (c == 0) return $urandom & 32'h7FFF;
        if (c <= 2) return 32'h8000 | ($urandom & 32'h3FFF);
        if (c == 3) return 32'hC000 + ($urandom & 32'h3FFF);
        return $urandom | 32'h0001_0000;
    endfunction
    task automatic do_reset();
        rst = 1'b1;
        bus.i_req = 0;
        bus.d_req = 0;
        bus.mem_read_data_ready = 1'($urandom_range(1));
        step();
        {e_valid, e_wv, e_iack, e_ierr, e_dack, e_derr} = '0;
        e_addr = 0;
        e_wd = '0;
        e_irdata = '0;
        e_drdata = '0;
        mptr = 1'b0;
        chk_en = 1'b1;
        chk("rst_mem_addr", line_t'(bus.mem_addr), '0);
        chk("rst_mem_write_data", bus.mem_write_data, '0);
        step();
        rst = 1'b0;
        bus.mem_read_data_ready = 0;
    endtask
    task automatic idle(input int n);
        bus.i_req = 0;
        bus.d_req = 0;
        for (int k = 0; k < n; k++) begin
            bus.mem_read_data_ready = 1'($urandom_range(1));
            step();
        end
        bus.mem_read_data_ready = 0;
    endtask
    task automatic resp(input logic gd, input logic er, input line_t rd);
        e_valid = 0;
        e_wv = 0;
        if (gd) begin
            e_dack = 1;
            e_derr = er;
            e_drdata = rd;
        end else begin
            e_iack = 1;
            e_ierr = er;
            e_irdata = rd;
        end
        bus.mem_read_data_ready = 1'($urandom_range(1));
        step();
        bus.mem_read_data_ready = 0;
        {e_iack, e_ierr, e_dack, e_derr} = '0;
        mptr = !gd;
    endtask
    task automatic txn(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input line_t dwd, input int dly, input line_t md, input int lim);
        logic gd, w, er;
        logic [31:0] a;
        bus.i_req = ir;
        bus.i_addr = ia;
        bus.d_req = dr;
        bus.d_we = dw;
        bus.d_addr = da;
        bus.d_wdata = dwd;
        bus.mem_read_data = md;
        bus.mem_read_data_ready = 1'($urandom_range(1));
        gd = dr && (!ir || mptr);
        a = gd ? da : ia;
        w = gd && dw;
        er = !(a < 32'h0000_C000) || (w && a < 32'h0000_8000);
        gl.push_back(a);
        step();
        bus.mem_read_data_ready = 0;
        if (er) resp(gd, 1'b1, '0);
        else begin
            e_valid = 1;
            e_addr = a;
            e_wv = w;
            e_wd = w ? dwd : '0;
            for (int k = 1; k <= lim; k++) begin
                bus.mem_read_data_ready = (k == dly);
                step();
                bus.mem_read_data_ready = 0;
                if (k == dly) begin
                    resp(gd, 1'b0, w ? '0 : md);
                    break;
                end
                if (k == TMO) begin
                    resp(gd, 1'b1, '0);
                    break;
                end
            end
        end
    endtask
    initial begin
        line_t a5, w12;
        a5 = {(LW / 32){32'hA5A5_A5A5}};
        w12 = {(LW / 32){32'h1234_5678}};
        bus.i_req = 0;
        bus.i_addr = 0;
        bus.d_req = 0;
        bus.d_we = 0;
        bus.d_addr = 0;
        bus.d_wdata = '0;
        bus.mem_read_data_ready = 0;
        bus.mem_read_data = '0;
        do_reset();
        for (int p = 0; p < 8; p++) txn(1, 32'h0, 1, 0, 32'h8000, rline(), 2, rline(), 50);
        for (int p = 0; p < 8; p++) chk("pair_order", line_t'(gl[p]), (p % 2) ? line_t'(32'h8000) : '0);
        chk("pair_ptr", line_t'(mptr), '0);
        txn(1, 32'h40, 0, 0, 32'h0, rline(), 3, a5, 50);
        chk("i_read_hold", bus.i_rdata, a5);
        chk("i_read_ptr", line_t'(mptr), line_t'(1'b1));
        txn(0, 32'h0, 1, 1, 32'h8010, w12, 2, rline(), 50);
        chk("d_write_rdata", bus.d_rdata, '0);
        txn(0, 32'h0, 1, 1, 32'h0100, rline(), 2, rline(), 50);
        txn(1, 32'h0001_0000, 0, 0, 32'h0, rline(), 2, rline(), 50);
        chk("err_i_rdata", bus.i_rdata, '0);
`ifdef MEM_ARB_TIMEOUT_EN
        txn(1, 32'h80, 0, 0, 32'h0, rline(), TO, a5, 100);
        chk("ready_at_timeout", bus.i_rdata, a5);
`endif
        txn(1, 32'h40, 0, 0, 32'h0, rline(), 0, rline(), 100);
        do_reset();
        txn(1, 32'h40, 0, 0, 32'h0, rline(), 0, rline(), 2);
        do_reset();
        txn(1, 32'h80, 1, 0, 32'h8020, rline(), 1, rline(), 50);
        chk("post_reset_i_first", line_t'(gl[gl.size() - 1]), line_t'(32'h80));
        for (int t = 0; t < 400; t++) begin
            logic ir, dr;
            ir = 1'($urandom_range(1));
            dr = 1'($urandom_range(1));
            if ($urandom_range(60) == 0) do_reset();
            else if (!ir && !dr) idle($urandom_range(1, 3));
            else txn(ir, raddr(), dr, 1'($urandom_range(1)), raddr(), rline(), $urandom_range(1, 10), rline(), 50);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 64: BUSY cycles without completion before error (TIMEOUT only).
REQ-002 SHALL provide parameter LINE_W, default 512: width of data buses in bits.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req in 1, i_addr in 32, i_ack out 1, i_err out 1, i_rdata out LINE_W: instruction requester, read-only.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in LINE_W, d_ack out 1, d_err out 1, d_rdata out LINE_W: data requester, read/write.
REQ-007 SHALL have ports mem_addr_valid out 1, mem_addr out 32, mem_write_data_valid out 1, mem_write_data out LINE_W: shared memory bus request.
REQ-008 SHALL have ports mem_read_data_ready in 1, mem_read_data in LINE_W: shared completion strobe and read line.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, RESP; one transaction in flight at most.
REQ-010 IDLE: requests sampled only here; if any req high, SHALL grant per priority pointer, latch addr/we/wdata, go BUSY (or RESP on decode error).
REQ-011 Priority pointer SHALL select i on simultaneous requests when 0, d when 1; SHALL point to the non-granted requester after each RESP.
REQ-012 Lone request SHALL be granted regardless of pointer.
REQ-013 Decode: ROM = addr[31:15]==0, RAM = addr[31:14]==2; any other address, or d_we=1 to ROM, SHALL skip BUSY and go RESP with err=1, rdata=0, no bus activity.
REQ-014 BUSY: mem_addr_valid=1, mem_addr=latched address, mem_write_data_valid=latched we, mem_write_data=latched wdata (zero on reads), held stable every BUSY cycle.
REQ-015 BUSY: on mem_read_data_ready=1 SHALL capture mem_read_data (reads) and go RESP; same-cycle completion after entering BUSY never occurs (earliest ready sampled 1 cycle after mem_addr_valid rises).
REQ-016 mem_read_data_ready outside BUSY SHALL be ignored.
REQ-017 RESP (one cycle): granted port's ack=1, rdata=captured line (0 for writes/errors), err as resolved; then IDLE. Non-granted ack/err SHALL stay 0.
REQ-018 Latency: req high at IDLE edge N -> mem_addr_valid at N+1; ready sampled at edge M -> ack at M+1; decode error -> ack at N+1.
REQ-019 Requesters SHALL hold req/addr/we/wdata until ack and may reassert next cycle; re-request seen in IDLE the cycle after RESP.
REQ-020 rdata outputs SHALL hold their value between acks.

Reset
REQ-021 rst SHALL force IDLE, pointer=0, timeout counter=0, all outputs 0, captured line 0.
REQ-022 rst mid-BUSY/RESP SHALL abandon the transaction: no ack, mem_addr_valid low next cycle.

Configuration
REQ-023 Macro MEM_ARB_TIMEOUT_EN defined: counter counts BUSY cycles; at TIMEOUT_CYCLES without ready SHALL drop mem_addr_valid and go RESP with err=1, rdata=0; ready in that same cycle wins (normal completion).
REQ-024 Macro undefined: no counter; BUSY waits indefinitely; err only from decode.

Verification
REQ-025 i_req read 0x0000_0040, ready 3 cycles after valid, data 0xA5.. -> i_ack one cycle, i_rdata=line, i_err=0, d_ack=0.
REQ-026 i_req and d_req both high from reset, addresses 0x0 and 0x8000 -> i granted first, then d; mem_addr 0x0 then 0x8000; pointer alternates over 4 back-to-back pairs.
REQ-027 d write 0x0000_8010 wdata 0x1234.. -> mem_write_data_valid=1 with wdata while BUSY; d_ack, d_err=0, d_rdata=0.
REQ-028 d write to 0x0000_0100 and i read 0x0001_0000 -> err=1 ack at N+1, mem_addr_valid never asserted.
REQ-029 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ready -> ack with err=1 after 8 BUSY cycles; without macro, no ack after 100 cycles.
REQ-030 rst pulsed 2 cycles into BUSY -> no ack, all outputs 0, next request serviced normally with i priority.
